// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared encodings for the registered next-PC unit: control-flow op codes and FSM states.
package pc_redirect_ctrl_pkg;

   typedef enum logic [2:0] {
      BR_NONE  = 3'b000,
      BR_BMV   = 3'b001,
      BR_BZ    = 3'b010,
      BR_RSVD  = 3'b011,
      BR_JSP   = 3'b100,
      BR_BALRN = 3'b101,
      BR_JMADD = 3'b110,
      BR_RET   = 3'b111
   } br_op_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } state_e;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Op/flag inputs, memory target handshake and PC outputs of the next-PC unit.
interface pc_redirect_ctrl_if #(
   parameter int XLEN    = 32,
   parameter int JADDR_W = 26
);
   logic               op_valid;
   logic [2:0]         br_op;
   logic               hold;
   logic               flag_n;
   logic               flag_z;
   logic               flag_v;
   logic [XLEN-1:0]    reg_target;
   logic [JADDR_W-1:0] jmp_addr;
   logic [XLEN-1:0]    mem_rdata;
   logic               mem_valid;
   logic               mem_req;
   logic [XLEN-1:0]    pc;
   logic [XLEN-1:0]    pc_plus4;
   logic               redirect;
   logic               stall;
   logic               ras_underflow;

   modport master (
      output op_valid, br_op, hold, flag_n, flag_z, flag_v,
             reg_target, jmp_addr, mem_rdata, mem_valid,
      input  mem_req, pc, pc_plus4, redirect, stall, ras_underflow
   );

   modport slave (
      input  op_valid, br_op, hold, flag_n, flag_z, flag_v,
             reg_target, jmp_addr, mem_rdata, mem_valid,
      output mem_req, pc, pc_plus4, redirect, stall, ras_underflow
   );
endinterface

// File: rtl/pc_redirect_ctrl_ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_inc;
   logic [CNT_W-1:0] cnt_q;

   assign ptr_inc = ptr_q + PTR_W'(1);
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign top     = mem[ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else if (push) begin
         ptr_q <= ptr_inc;
         if (!full) cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop && !empty) begin
         ptr_q <= ptr_q - PTR_W'(1);
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Storage carries no reset; validity is tracked by cnt_q alone.
   always_ff @(posedge clk) begin
      if (push) mem[ptr_inc] <= push_data;
   end
endmodule

// File: rtl/pc_redirect_ctrl.sv
// Registered next-PC unit: resolves custom control-flow ops, waits on memory targets, owns the RAS.
//   state       | meaning
//   ST_IDLE     | accepting ops, PC advances unless hold
//   ST_WAIT_MEM | memory target outstanding, stall asserted, op/hold ignored
module pc_redirect_ctrl
   import pc_redirect_ctrl_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              JADDR_W   = 26,
   parameter int              RAS_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input logic              clk,
   input logic              reset,
   pc_redirect_ctrl_if.slave bus
);
   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
   logic            redirect_q, redirect_d;
   logic            uf_q, uf_d;
   logic            stall;
   logic            ras_push, ras_pop;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty, ras_full;

   assign pc_plus4 = pc_q + XLEN'(4);

   ras_stack #(.DEPTH(RAS_DEPTH), .WIDTH(XLEN)) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus4),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redirect_d = 1'b0;
      uf_d       = 1'b0;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;
      stall      = 1'b0;
      case (state_q)
         ST_WAIT_MEM: begin
            stall = 1'b1;
            if (bus.mem_valid) begin
               pc_d       = bus.mem_rdata;
               redirect_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            if (!bus.hold) begin
               pc_d = pc_plus4;
               if (bus.op_valid) begin
                  case (bus.br_op)
                     BR_BZ: begin
                        if (bus.flag_z) begin
                           pc_d       = {pc_plus4[XLEN-1:JADDR_W+2], bus.jmp_addr, 2'b00};
                           redirect_d = 1'b1;
                        end
                     end
                     BR_BALRN: begin
                        if (bus.flag_n) begin
                           pc_d       = bus.reg_target;
                           ras_push   = 1'b1;
                           redirect_d = 1'b1;
                        end
                     end
                     BR_RET: begin
                        if (!ras_empty) begin
                           pc_d       = ras_top;
                           ras_pop    = 1'b1;
                           redirect_d = 1'b1;
                        end else begin
                           uf_d = 1'b1;
                        end
                     end
                     BR_BMV: begin
                        if (bus.flag_v) begin
                           stall   = 1'b1;
                           pc_d    = pc_q;
                           state_d = ST_WAIT_MEM;
                        end
                     end
                     BR_JSP, BR_JMADD: begin
                        stall   = 1'b1;
                        pc_d    = pc_q;
                        state_d = ST_WAIT_MEM;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         redirect_q <= 1'b0;
         uf_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         uf_q       <= uf_d;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_plus4      = pc_plus4;
   assign bus.redirect      = redirect_q;
   assign bus.ras_underflow = uf_q;
   assign bus.stall         = stall;
   assign bus.mem_req       = (state_q == ST_WAIT_MEM);

   logic unused_full;
   assign unused_full = ras_full;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: driver pushes model expectations, negedge monitor compares.
module tb_pc_redirect_ctrl;
   import pc_redirect_ctrl_pkg::*;

   localparam int          XLEN      = 32;
   localparam int          JADDR_W   = 26;
   localparam int          RAS_DEPTH = 4;
   localparam logic [31:0] RESET_PC  = 32'h0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_redirect_ctrl_if #(.XLEN(XLEN), .JADDR_W(JADDR_W)) bus ();

   pc_redirect_ctrl #(
      .XLEN(XLEN), .JADDR_W(JADDR_W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic        stall;
      logic        mem_req;
      logic        redirect;
      logic        uf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state (values visible after the most recent edge)
   logic [31:0] m_pc;
   logic        m_wait, m_red, m_uf;
   logic [31:0] m_ras[$];
   logic        model_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc", bus.pc, e.pc);
         chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
         chk("stall", {31'b0, bus.stall}, {31'b0, e.stall});
         chk("mem_req", {31'b0, bus.mem_req}, {31'b0, e.mem_req});
         chk("redirect", {31'b0, bus.redirect}, {31'b0, e.redirect});
         chk("ras_underflow", {31'b0, bus.ras_underflow}, {31'b0, e.uf});
      end
   end

   task automatic step(input logic rst, input logic ov, input logic [2:0] op, input logic hd,
                       input logic n, input logic z, input logic v, input logic [31:0] rt,
                       input logic [25:0] ja, input logic [31:0] rd, input logic mv);
      exp_t        e;
      logic [31:0] p4;
      logic [31:0] hi_mask;
      logic        mem_op;
      reset          = rst;
      bus.op_valid   = ov;
      bus.br_op      = op;
      bus.hold       = hd;
      bus.flag_n     = n;
      bus.flag_z     = z;
      bus.flag_v     = v;
      bus.reg_target = rt;
      bus.jmp_addr   = ja;
      bus.mem_rdata  = rd;
      bus.mem_valid  = mv;

      mem_op = (op == BR_JSP) || (op == BR_JMADD) || ((op == BR_BMV) && v);
      if (model_valid) begin
         e.pc       = m_pc;
         e.mem_req  = m_wait;
         e.redirect = m_red;
         e.uf       = m_uf;
         e.stall    = m_wait || (!hd && ov && mem_op);
         exp_q.push_back(e);
      end

      p4      = m_pc + 32'd4;
      hi_mask = ~((32'd1 << (JADDR_W + 2)) - 32'd1);
      m_red   = 1'b0;
      m_uf    = 1'b0;
      if (rst) begin
         m_pc   = RESET_PC;
         m_wait = 1'b0;
         m_ras.delete();
         model_valid = 1'b1;
      end else if (m_wait) begin
         if (mv) begin
            m_pc   = rd;
            m_wait = 1'b0;
            m_red  = 1'b1;
         end
      end else if (!hd) begin
         m_pc = p4;
         if (ov) begin
            if (op == BR_BZ && z) begin
               m_pc  = (p4 & hi_mask) | {4'b0, ja, 2'b00};
               m_red = 1'b1;
            end else if (op == BR_BALRN && n) begin
               m_ras.push_back(p4);
               if (m_ras.size() > RAS_DEPTH) m_ras.delete(0);
               m_pc  = rt;
               m_red = 1'b1;
            end else if (op == BR_RET) begin
               if (m_ras.size() > 0) begin
                  m_pc  = m_ras.pop_back();
                  m_red = 1'b1;
               end else begin
                  m_uf = 1'b1;
               end
            end else if (mem_op) begin
               m_pc   = m_pc - 32'd4;
               m_wait = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_op(input logic [2:0] op, input logic n, input logic z, input logic v,
                        input logic [31:0] rt, input logic [25:0] ja);
      step(0, 1, op, 0, n, z, v, rt, ja, $urandom, 0);
   endtask

   task automatic set_pc(input logic [31:0] target);
      do_op(BR_JSP, 0, 0, 0, 0, 0);
      step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, target, 1);
   endtask

   initial begin
      step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);

      set_pc(32'h100);
      do_op(BR_BZ, 0, 1, 0, 0, 26'h40);
      set_pc(32'h100);
      do_op(BR_BZ, 0, 0, 0, 0, 26'h40);

      set_pc(32'h200);
      do_op(BR_JSP, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(0, 1, 3'($urandom_range(0, 7)), 1'($urandom), 1, 1, 1, $urandom, 26'($urandom), $urandom, 0);
      step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 32'h800, 1);
      idle(2);

      set_pc(32'h20);
      do_op(BR_BALRN, 1, 0, 0, 32'h1000, 0);
      do_op(BR_RET, 0, 0, 0, 0, 0);
      do_op(BR_RET, 0, 0, 0, 0, 0);
      idle(1);

      for (int i = 0; i < 5; i++) do_op(BR_BALRN, 1, 0, 0, 32'h4000 + 32'(i) * 32'h100, 0);
      for (int i = 0; i < 5; i++) do_op(BR_RET, 0, 0, 0, 0, 0);
      do_op(BR_BMV, 0, 0, 0, 0, 0);
      do_op(BR_BALRN, 0, 0, 0, 32'h9000, 0);
      idle(1);

      do_op(BR_JMADD, 0, 0, 0, 0, 0);
      idle(1);
      step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 32'hDEAD_0000, 0);
      step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 32'hBEEF_0000, 1);
      for (int i = 0; i < 3; i++) step(0, 1, BR_BZ, 1, 0, 1, 0, 0, 26'h55, 0, 0);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rt, rd;
         rt = $urandom & 32'hFFFF_FFFC;
         rd = $urandom & 32'hFFFF_FFFC;
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
              3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
              1'($urandom), 1'($urandom), 1'($urandom), rt, 26'($urandom), rd,
              (m_wait ? ($urandom_range(0, 2) == 0) : 1'($urandom)));
      end
      idle(2);
      #20;
      chk("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Registered next-PC unit for the extended MIPS datapath; successor to the combinational jump/branch selector. Owns the PC register and resolves the custom control-flow ops (bmv, bz, jsp, balrn, jmadd) plus a new return op (ret). Memory-sourced targets use a req/valid wait state instead of a same-cycle memory read. A parametrised return-address stack (RAS) serves balrn/ret.

Parameters:
XLEN, 32, PC/data width in bits
JADDR_W, 26, width of instruction jump-address field
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_valid  in  1  br_op is valid this cycle
br_op  in  3  000 none, 001 bmv, 010 bz, 100 jsp, 101 balrn, 110 jmadd, 111 ret; 011 reserved
hold  in  1  pipeline freeze; PC does not advance in IDLE
flag_n  in  1  ALU negative flag
flag_z  in  1  ALU zero flag
flag_v  in  1  ALU overflow flag
reg_target  in  XLEN  register-file target (balrn)
jmp_addr  in  JADDR_W  instruction jump field (bz)
mem_rdata  in  XLEN  target word returned by data memory
mem_valid  in  1  mem_rdata valid
mem_req  out  1  memory target request, held until mem_valid
pc  out  XLEN  current PC (registered)
pc_plus4  out  XLEN  pc + 4, combinational, wraps modulo 2^XLEN
redirect  out  1  one-cycle pulse: pc loaded with non-sequential target on the preceding edge
stall  out  1  fetch must hold; upstream keeps op stable
ras_underflow  out  1  one-cycle pulse: ret with empty RAS

Behaviour:
- Reset (sync, active-high): pc=RESET_PC, state=IDLE, mem_req=0, redirect=0, ras_underflow=0, RAS count=0, top pointer=0. Applies from any state, including mid-WAIT_MEM; an outstanding memory response is dropped.
- States: IDLE, WAIT_MEM.
- IDLE, hold=1: pc unchanged, op ignored, stall=0.
- IDLE, op_valid=0 or br_op=000/011: pc <= pc_plus4, redirect=0.
- bz: z=1 -> pc <= {pc_plus4[XLEN-1:JADDR_W+2], jmp_addr, 2'b00}, redirect; else pc_plus4.
- balrn: n=1 -> pc <= reg_target, push pc_plus4 on RAS, redirect; n=0 -> pc_plus4, no push.
- ret: RAS non-empty -> pc <= top, pop, redirect; empty -> pc <= pc_plus4, ras_underflow pulse.
- bmv with v=0: pc <= pc_plus4, no memory access.
- jsp, jmadd, bmv with v=1: stall=1 combinationally in that cycle, pc unchanged, go to WAIT_MEM, mem_req=1 from next cycle.
- WAIT_MEM: stall=1, mem_req=1, op inputs and hold ignored. On mem_valid: pc <= mem_rdata, mem_req<=0, state<=IDLE, redirect pulse next cycle. No timeout.
- mem_valid in IDLE is ignored.
- RAS full push: overwrite oldest entry (circular), count saturates at RAS_DEPTH.
- Flags sampled only in the cycle the op is accepted.
- Only one op is accepted per cycle; no same-cycle push and pop.

Decomposition:
- Shared package: br_op encodings (BR_NONE, BR_BMV, BR_BZ, BR_JSP, BR_BALRN, BR_JMADD, BR_RET) and the state enum; the decoder and testbench import them.
- One sub-module: ras_stack (parametrised depth/width, push/pop, top, empty, full, circular overwrite).

Test Plan:
- Reset then 3 idle cycles, RESET_PC=0 -> pc 0,4,8,0xC; redirect=0, stall=0.
- pc=0x100, bz, z=1, jmp_addr=0x40 -> pc=0x100 next cycle, redirect pulse; same op with z=0 -> pc=0x104.
- pc=0x200, jsp -> stall same cycle, mem_req from next cycle; mem_valid after 3 cycles with rdata=0x800 -> pc=0x800, redirect 1 cycle, mem_req=0; pc held at 0x200 throughout the wait.
- balrn n=1 reg_target=0x1000 at pc=0x20 -> pc=0x1000, RAS top=0x24; ret -> pc=0x24; second ret -> pc=0x28, ras_underflow pulse.
- RAS_DEPTH=4: five taken balrn (links A..E), then five rets -> E,D,C,B, then underflow on the fifth; bmv v=0 -> pc+4, mem_req never asserted.
- Reset asserted during WAIT_MEM, mem_valid in the following cycle -> pc=RESET_PC, mem_valid ignored, state IDLE; hold=1 in IDLE -> pc frozen.
